regfile_wb_sched: RTL
=====================

# regfile_wb_sched

Write-port scheduler and scoreboard for the 32×64 GPR file. It shares the file's single write port between the in-order pipeline writeback and the long-latency unit (mul/div, valid/ready). It holds one pending long-latency result and tracks which destination registers still await a long-latency write, so the hazard logic can stall dependent instructions.

## Interface
- REG_FILE_BITS, 5, register index width
- REG_FILE_SIZE, 32, number of GPRs
- REG_SIZE, 64, register width
- STARVE_LIMIT, 4, wait cycles before the buffer forces a pipeline bubble (≥1)

Clock and reset are fixed: one clock; reset is synchronous and active-high.

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- pipe_we  in  1  pipeline writeback valid; must be honoured the same cycle
- pipe_rd  in  REG_FILE_BITS  pipeline destination
- pipe_data  in  REG_SIZE  pipeline result
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  long-unit result accepted when lu_valid & lu_ready
- lu_rd  in  REG_FILE_BITS  long-unit destination
- lu_data  in  REG_SIZE  long-unit result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  REG_FILE_BITS  its destination
- chk_rs1, chk_rs2, chk_rd  in  REG_FILE_BITS each  operands/destination of the instruction in decode
- dep_stall  out  1  busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]
- wb_hold  out  1  pipeline must present no register write this cycle
- busy_vec  out  REG_FILE_SIZE  scoreboard
- protocol_err  out  1  sticky contract-violation flag
- rf_we  out  1  to register file write enable
- rf_write_num  out  REG_FILE_BITS  to register file write index
- rf_in_value  out  REG_SIZE  to register file write data

## Operation
- Effective pipe write: pw = pipe_we & (pipe_rd != 0).
- Port select:
  - If pw, the port carries pipe_rd/pipe_data.
  - Else if buf_valid, the port carries the buffered result (this is a drain).
  - Else rf_we = 0.
- drain = buf_valid & !pw.
- lu_ready = !rst & (!buf_valid | drain). An accepted result loads the buffer. It never goes to the port in its acceptance cycle.
- Scoreboard:
  - iss_valid with iss_rd != 0 sets busy[iss_rd].
  - A drain clears busy[buf_rd].
  - If both hit the same index in one cycle, set wins.
  - busy[0] is constantly 0.
- dep_stall is combinational from busy_vec and the chk_* inputs.
- Starvation guard (see Configuration):
  - age increments while buf_valid & !drain, saturating at STARVE_LIMIT.
  - age resets to 0 on a drain, or on a load into an empty buffer.
  - wb_hold = (age == STARVE_LIMIT).
- protocol_err is set, and held until rst, on any of:
  - iss_valid to an already-busy rd (WAW not stalled)
  - pw while wb_hold
  - lu_valid with lu_rd not busy
  - lu_rd == 0

## Timing
- Reset values:
  - buf_valid = 0, busy_vec = 0, age = 0, protocol_err = 0.
  - Outputs during rst: rf_we = 0, lu_ready = 0, wb_hold = 0, dep_stall = 0.
- Port outputs are combinational from pipe_* and buffer registers. They are stable before negedge, when the register file samples them.
- Long-unit latency:
  - Accepted in cycle N; written in cycle N+1 at the earliest.
  - busy clears at posedge ending the drain cycle, so dep_stall drops in the following cycle.
- Throughput is one long-unit result per cycle while pw = 0 (accept and drain in the same cycle).
- Buffer full and pw = 1: lu_ready = 0 and the result is held upstream.
- If pw and wb_hold occur together (contract violation), the pipe still wins, the buffer waits, and protocol_err is set.
- rst mid-operation discards the buffered result and clears all busy bits. Upstream flushes the long unit on the same reset.

## Configuration
- REGFILE_WB_STARVE_GUARD_EN defined: the age counter and wb_hold behave as above. Worst-case buffer wait is STARVE_LIMIT+1 cycles.
- Not defined:
  - No age counter.
  - wb_hold is tied 0 and the "pw while wb_hold" check is removed.
  - The buffer waits for a natural pipeline bubble.

## Test plan
- Reset, then lu_valid lu_rd=5 with pw=0:
  - lu_ready=1 in cycle N.
  - rf_we=1, rf_write_num=5 in N+1.
  - busy[5] clears after N+1.
- iss_valid iss_rd=7, then chk_rs1=7 -> dep_stall=1 until busy[7] clears; chk_rs1=0 -> dep_stall=0 always.
- Buffered result for rd=3 with pw every cycle (guard enabled, STARVE_LIMIT=4):
  - wb_hold=1 after 4 waiting cycles.
  - Pipe idles, the buffer drains, and wb_hold drops the next cycle.
  - With the macro undefined, the buffer waits indefinitely with no wb_hold.
- Drain of rd=9 in the same cycle as iss_valid iss_rd=9 -> busy[9] remains 1.
- Back-to-back lu results rd=1,2,3 with pw=0 -> lu_ready stays 1 and writes occur in consecutive cycles.
- pipe_we=1 with pipe_rd=0 while the buffer is full -> the buffer drains that cycle; rst mid-wait -> buf_valid=0, busy_vec=0, no write.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Signal bundle around the GPR write-port scheduler: pipeline writeback, long-unit results,
// issue/decode scoreboard queries and the register-file write port.
interface regfile_wb_sched_if #(
  parameter int unsigned REG_FILE_BITS = 5,
  parameter int unsigned REG_FILE_SIZE = 32,
  parameter int unsigned REG_SIZE      = 64
);
  logic                     pipe_we;
  logic [REG_FILE_BITS-1:0] pipe_rd;
  logic [REG_SIZE-1:0]      pipe_data;
  logic                     lu_valid;
  logic                     lu_ready;
  logic [REG_FILE_BITS-1:0] lu_rd;
  logic [REG_SIZE-1:0]      lu_data;
  logic                     iss_valid;
  logic [REG_FILE_BITS-1:0] iss_rd;
  logic [REG_FILE_BITS-1:0] chk_rs1;
  logic [REG_FILE_BITS-1:0] chk_rs2;
  logic [REG_FILE_BITS-1:0] chk_rd;
  logic                     dep_stall;
  logic                     wb_hold;
  logic [REG_FILE_SIZE-1:0] busy_vec;
  logic                     protocol_err;
  logic                     rf_we;
  logic [REG_FILE_BITS-1:0] rf_write_num;
  logic [REG_SIZE-1:0]      rf_in_value;

  modport master (
    output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    input  lu_ready, dep_stall, wb_hold, busy_vec, protocol_err,
    input  rf_we, rf_write_num, rf_in_value
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    output lu_ready, dep_stall, wb_hold, busy_vec, protocol_err,
    output rf_we, rf_write_num, rf_in_value
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Shares the GPR write port between pipeline writeback and a one-entry long-unit result buffer; keeps a busy scoreboard.
// Latency: pipe writes pass through combinationally; long-unit results are written one cycle after acceptance at the earliest.
// Backpressure: lu_ready drops while the buffer is full and the pipe owns the port; REGFILE_WB_STARVE_GUARD_EN adds a starvation wb_hold.
module regfile_wb_sched #(
  parameter int unsigned REG_FILE_BITS = 5,
  parameter int unsigned REG_FILE_SIZE = 32,
  parameter int unsigned REG_SIZE      = 64
`ifdef REGFILE_WB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_LIMIT  = 4
`endif
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);

  logic                     buf_valid_q, buf_valid_d;
  logic [REG_FILE_BITS-1:0] buf_rd_q, buf_rd_d;
  logic [REG_SIZE-1:0]      buf_data_q, buf_data_d;
  logic [REG_FILE_SIZE-1:0] busy_q, busy_d;
  logic                     err_q, err_d;
  logic                     pw, drain, lu_rdy, accept, iss_set, waw;
  logic                     hold;

  always_comb begin
    pw      = bus.pipe_we & (bus.pipe_rd != '0);
    drain   = buf_valid_q & ~pw;
    lu_rdy  = ~rst & (~buf_valid_q | drain);
    accept  = bus.lu_valid & lu_rdy;
    iss_set = bus.iss_valid & (bus.iss_rd != '0);
    // Re-issuing to the register being drained this cycle is legal: the set wins.
    waw     = busy_q[bus.iss_rd] & ~(drain & (buf_rd_q == bus.iss_rd));
  end

`ifdef REGFILE_WB_STARVE_GUARD_EN
  localparam int unsigned      AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (drain || (accept && !buf_valid_q)) begin
      age_d = '0;
    end else if (buf_valid_q && (age_q != AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign hold = ~rst & (age_q == AGE_MAX);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    if (accept) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = bus.lu_rd;
      buf_data_d  = bus.lu_data;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end

    busy_d = busy_q;
    if (drain) begin
      busy_d[buf_rd_q] = 1'b0;
    end
    if (iss_set) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    err_d = err_q
          | (bus.iss_valid & waw)
          | (bus.lu_valid & (~busy_q[bus.lu_rd] | (bus.lu_rd == '0)))
          | (pw & hold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      busy_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Payload needs no reset; it is only observed behind buf_valid_q.
  always_ff @(posedge clk) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

  assign bus.rf_we        = ~rst & (pw | buf_valid_q);
  assign bus.rf_write_num = pw ? bus.pipe_rd : buf_rd_q;
  assign bus.rf_in_value  = pw ? bus.pipe_data : buf_data_q;
  assign bus.lu_ready     = lu_rdy;
  assign bus.wb_hold      = hold;
  assign bus.dep_stall    = ~rst & (busy_q[bus.chk_rs1] | busy_q[bus.chk_rs2] | busy_q[bus.chk_rd]);
  assign bus.busy_vec     = busy_q;
  assign bus.protocol_err = err_q;

endmodule
